bfsk_demodulator: RTL and testbench

- Receive-side counterpart of the BFSK transmit chain (PISO → tone mux → 8-bit sample stream).
- Takes the 8-bit modulated sample stream and classifies each bit window as mark (high tone) or space (low tone) by counting midscale crossings.
- Reassembles classified bits MSB-first into a parallel byte and outputs it with a one-cycle valid pulse.
- Sits downstream of the modulator mux output, or of an ADC capture path, in the loopback/test top level.

---
 rtl/bfsk_demodulator.sv | 157 +++++++++++++++
 tb/tb_bfsk_demodulator.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bfsk_demodulator.sv
// BFSK receive path: counts midscale crossings (with hysteresis) per bit window,
// decides mark/space per window and assembles NBITS decisions MSB-first into a byte.
module bfsk_demodulator #(
    parameter int SPB    = 64,
    parameter int THRESH = 8,
    parameter int HYST   = 4,
    parameter int MID    = 128,
    parameter int NBITS  = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       sample_in,
    input  logic             sample_valid,
    input  logic             start,
    output logic             busy,
    output logic             bit_out,
    output logic             bit_strobe,
    output logic [NBITS-1:0] data_out,
    output logic             data_valid
);

    // state | meaning
    // IDLE  | waiting for start
    // PRIME | waiting for the first valid sample to seed the sign flag
    // RUN   | tracking crossings and closing bit windows
    typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;

    localparam int SW = (SPB > 1) ? $clog2(SPB) : 1;
    localparam int CW = $clog2(SPB + 1);
    localparam int BW = $clog2(NBITS + 1);

    localparam logic [8:0]    MID_C    = 9'(MID);
    localparam logic [8:0]    HI_C     = 9'(MID + HYST);
    localparam logic [8:0]    LO_C     = 9'(MID - HYST);
    localparam logic [SW-1:0] LAST_SMP = SW'(SPB - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(NBITS - 1);
    localparam logic [CW-1:0] SPB_C    = CW'(SPB);
    localparam logic [CW-1:0] THRESH_C = CW'(THRESH);

    state_t           state_q, state_d;
    logic [SW-1:0]    samp_cnt;
    logic [CW-1:0]    cross_cnt;
    logic [BW-1:0]    bit_cnt;
    logic [NBITS-2:0] shift_q;
    logic             sign_q;

    logic             sign_d;
    logic             consume;
    logic             cross_inc;
    logic             win_close;
    logic             frame_end;
    logic [CW-1:0]    cross_total;
    logic             bit_d;
    logic [NBITS-1:0] shift_next;
    logic [8:0]       smp9;

    assign smp9 = {1'b0, sample_in};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        sign_d    = sign_q;
        consume   = 1'b0;
        cross_inc = 1'b0;
        win_close = 1'b0;
        frame_end = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = PRIME;
                end
            end
            PRIME: begin
                if (sample_valid) begin
                    consume = 1'b1;
                    sign_d  = (smp9 >= MID_C);
                    state_d = RUN;
                end
            end
            RUN: begin
                if (sample_valid) begin
                    consume = 1'b1;
                    if (smp9 >= HI_C) begin
                        sign_d = 1'b1;
                    end else if (smp9 < LO_C) begin
                        sign_d = 1'b0;
                    end
                    cross_inc = (sign_d != sign_q);
                end
            end
            default: state_d = IDLE;
        endcase

        if (consume && (samp_cnt == LAST_SMP)) begin
            win_close = 1'b1;
            if (bit_cnt == LAST_BIT) begin
                frame_end = 1'b1;
                state_d   = IDLE;
            end
        end
    end

    // Crossing count includes the sample being consumed, saturating at SPB.
    assign cross_total = (cross_inc && (cross_cnt != SPB_C)) ? cross_cnt + 1'b1 : cross_cnt;
    assign bit_d       = (cross_total >= THRESH_C);
    assign shift_next  = {shift_q, bit_d};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            samp_cnt   <= '0;
            cross_cnt  <= '0;
            bit_cnt    <= '0;
            shift_q    <= '0;
            sign_q     <= 1'b0;
            bit_out    <= 1'b0;
            bit_strobe <= 1'b0;
            data_out   <= '0;
            data_valid <= 1'b0;
        end else begin
            bit_strobe <= win_close;
            data_valid <= frame_end;
            if ((state_q == IDLE) && start) begin
                samp_cnt  <= '0;
                cross_cnt <= '0;
                bit_cnt   <= '0;
            end
            if (consume) begin
                sign_q <= sign_d;
                if (win_close) begin
                    samp_cnt  <= '0;
                    cross_cnt <= '0;
                    bit_out   <= bit_d;
                    shift_q   <= shift_next[NBITS-2:0];
                    if (frame_end) begin
                        bit_cnt  <= '0;
                        data_out <= shift_next;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end else begin
                    samp_cnt  <= samp_cnt + 1'b1;
                    cross_cnt <= cross_total;
                end
            end
        end
    end

    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_bfsk_demodulator.sv
// Directed bench for bfsk_demodulator: window/frame tables, a strobe/data monitor,
// and hand sequences for mid-frame reset and back-to-back frames.
module tb_bfsk_demodulator;

    localparam int SPB = 64;
    localparam int K_SQ   = 0;  // square wave 200/56, n=1 mark (period 8), n=0 space (period 32)
    localparam int K_CNT  = 1;  // exactly n crossings, otherwise hold level
    localparam int K_HIN  = 2;  // 125/131 alternation, inside hysteresis
    localparam int K_HOUT = 3;  // 122/134 alternation, crosses every sample

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] sample_in = 8'd0;
    logic       sample_valid = 1'b0;
    logic       start = 1'b0;
    logic       busy, bit_out, bit_strobe, data_valid;
    logic [7:0] data_out;

    bfsk_demodulator dut (
        .clk(clk), .reset(reset), .sample_in(sample_in), .sample_valid(sample_valid),
        .start(start), .busy(busy), .bit_out(bit_out), .bit_strobe(bit_strobe),
        .data_out(data_out), .data_valid(data_valid)
    );

    always #10 clk = ~clk;

    typedef struct { int kind; int n; bit exp_bit; } win_t;
    typedef struct { int first; int nwin; logic [7:0] byte_v; bit gap; int pulse_at; } frame_t;

    win_t       wins[$];
    frame_t     frames[3];
    bit         exp_q[$];
    logic [7:0] exp_bytes[$];
    int         n_cmp = 0;
    int         n_err = 0;
    int         strobe_cnt = 0;
    int         dv_cnt = 0;
    int         smp_cnt = 0;
    bit         gap_en = 1'b0;
    bit         tb_sign = 1'b0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (bit_strobe === 1'b1) begin
            strobe_cnt++;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_strobe: got strobe expected none at %0t", $time);
            end else begin
                check("bit_out", bit_out, exp_q.pop_front());
            end
        end
        if (data_valid === 1'b1) begin
            dv_cnt++;
            if (exp_bytes.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_dv: got data_valid expected none at %0t", $time);
            end else begin
                check("data_out", data_out, exp_bytes.pop_front());
            end
            check("dv_with_strobe", bit_strobe, 1);
            check("busy_at_dv", busy, 0);
        end
    end

    task automatic drive_sample(logic [7:0] v);
        @(negedge clk);
        sample_in    = v;
        sample_valid = 1'b1;
        smp_cnt++;
        if (gap_en && (smp_cnt % 5 == 0)) begin
            repeat (3) begin
                @(negedge clk);
                sample_valid = 1'b0;
                sample_in    = tb_sign ? 8'd0 : 8'd255;
            end
        end
    endtask

    task automatic send_window(win_t w, bit first);
        logic [7:0] v;
        bit s0;
        s0 = tb_sign;
        exp_q.push_back(w.exp_bit);
        for (int s = 0; s < SPB; s++) begin
            case (w.kind)
                K_SQ: begin
                    v = (((s / (w.n != 0 ? 4 : 16)) % 2) == 0) ? 8'd200 : 8'd56;
                    tb_sign = (v >= 8'd128);
                end
                K_CNT: begin
                    if (s >= int'(first) && s < int'(first) + w.n) tb_sign = ~tb_sign;
                    v = tb_sign ? 8'd200 : 8'd56;
                end
                K_HIN:   v = (s % 2 != 0) ? 8'd131 : 8'd125;
                default: v = (s0 ^ (s % 2 == 0)) ? 8'd134 : 8'd122;
            endcase
            drive_sample(v);
        end
    endtask

    task automatic do_start(bit expect_dv);
        @(negedge clk);
        start        = 1'b1;
        sample_valid = 1'b0;
        if (expect_dv) begin
            #1;
            check("dv_at_b2b_start", data_valid, 1);
        end
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", busy, 1);
    endtask

    task automatic send_frame(int first, int nwin, logic [7:0] byte_v, bit gap, int pulse_at, bit b2b);
        exp_bytes.push_back(byte_v);
        gap_en = gap;
        do_start(b2b);
        for (int w = 0; w < nwin; w++) begin
            if (w == pulse_at) begin
                @(negedge clk);
                sample_valid = 1'b0;
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
                check("busy_start_in_run", busy, 1);
            end
            send_window(wins[first + w], (w == 0));
        end
    endtask

    task automatic wait_dv(int target);
        int t;
        t = 0;
        @(negedge clk);
        sample_valid = 1'b0;
        while (dv_cnt < target && t < 20) begin
            @(negedge clk);
            #1;
            t++;
        end
        repeat (3) @(negedge clk);
        #1;
        check("dv_count", dv_cnt, target);
        check("busy_after_frame", busy, 0);
        check("exp_bits_drained", exp_q.size(), 0);
    endtask

    task automatic push_square(logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            win_t w;
            w.kind = K_SQ;
            w.n = int'(b[i]);
            w.exp_bit = b[i];
            wins.push_back(w);
        end
    endtask

    initial begin
        int sb;
        push_square(8'h99);                      // 0..7
        wins.push_back('{K_CNT,  8, 1'b1});      // 8: exactly THRESH
        wins.push_back('{K_CNT,  7, 1'b0});      // 9: THRESH-1
        wins.push_back('{K_HIN,  0, 1'b0});      // 10
        wins.push_back('{K_HOUT, 0, 1'b1});      // 11
        wins.push_back('{K_CNT,  7, 1'b0});      // 12
        wins.push_back('{K_CNT,  8, 1'b1});      // 13
        wins.push_back('{K_HOUT, 0, 1'b1});      // 14
        wins.push_back('{K_HIN,  0, 1'b0});      // 15
        push_square(8'hA5);                      // 16..23
        push_square(8'h3C);                      // 24..31
        frames[0] = '{0, 8, 8'h99, 1'b0, -1};
        frames[1] = '{8, 8, 8'h96, 1'b0, -1};
        frames[2] = '{0, 8, 8'h99, 1'b1, 3};

        #25;
        check("rst_busy", busy, 0);
        check("rst_bit_out", bit_out, 0);
        check("rst_bit_strobe", bit_strobe, 0);
        check("rst_data_out", data_out, 0);
        check("rst_data_valid", data_valid, 0);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        for (int f = 0; f < 3; f++) begin
            sb = strobe_cnt;
            send_frame(frames[f].first, frames[f].nwin, frames[f].byte_v,
                       frames[f].gap, frames[f].pulse_at, 1'b0);
            wait_dv(f + 1);
            check("strobes_per_frame", strobe_cnt - sb, 8);
            check("data_out_hold", data_out, frames[f].byte_v);
        end
        gap_en = 1'b0;

        // Reset after three decisions: partial byte discarded, outputs clear at once.
        sb = strobe_cnt;
        do_start(1'b0);
        for (int w = 0; w < 3; w++) send_window(wins[16 + w], (w == 0));
        @(negedge clk);
        sample_valid = 1'b0;
        #1;
        check("pre_reset_bit_out", bit_out, 1);
        check("pre_reset_busy", busy, 1);
        #2;
        reset = 1'b0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_bit_out", bit_out, 0);
        check("mid_rst_bit_strobe", bit_strobe, 0);
        check("mid_rst_data_out", data_out, 0);
        check("mid_rst_data_valid", data_valid, 0);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("rst_no_dv", dv_cnt, 3);
        check("rst_strobes", strobe_cnt - sb, 3);
        check("rst_exp_drained", exp_q.size(), 0);

        // 0xA5 followed back-to-back by 0x3C with start held in the data_valid cycle.
        sb = strobe_cnt;
        send_frame(16, 8, 8'hA5, 1'b0, -1, 1'b0);
        send_frame(24, 8, 8'h3C, 1'b0, -1, 1'b1);
        wait_dv(5);
        check("b2b_strobes", strobe_cnt - sb, 16);
        check("b2b_data_out", data_out, 8'h3C);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #4000000;
        $display("FAIL global_timeout: got no finish expected finish by 4ms");
        $fatal(1, "timeout");
    end

endmodule
